// File: rtl/alu_seq_if.sv
// Op/result bus between the decoder/register file and alu_seq.
// The master drives operands; the slave (ALU) returns result and flags.
interface alu_seq_if #(
   parameter int unsigned WIDTH = 8
) ();
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic [WIDTH-1:0] out;
   logic [WIDTH-1:0] out_hi;
   logic             flag_zero;
   logic             flag_carry;
   logic             flag_neg;
   logic             flag_ovf;

   modport master (
      output in_valid, op, a, b,
      input  in_ready, out_valid, out, out_hi,
      input  flag_zero, flag_carry, flag_neg, flag_ovf
   );

   modport slave (
      input  in_valid, op, a, b,
      output in_ready, out_valid, out, out_hi,
      output flag_zero, flag_carry, flag_neg, flag_ovf
   );
endinterface

// File: rtl/alu_seq.sv
// Handshaked registered ALU: single-cycle arith/logic/shift/swap ops and an
// iterative shift-add multiplier that back-pressures the op stream while busy.
module alu_seq #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned MUL_EN = 1
) (
   input  logic     clk,
   input  logic     rst_n,
   alu_seq_if.slave bus
);
   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned HW = WIDTH / 2;
   localparam int unsigned MSB = WIDTH - 1;

   localparam logic [3:0] OP_PASS = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_INC  = 4'd3;
   localparam logic [3:0] OP_DEC  = 4'd4;
   localparam logic [3:0] OP_AND  = 4'd5;
   localparam logic [3:0] OP_OR   = 4'd6;
   localparam logic [3:0] OP_XOR  = 4'd7;
   localparam logic [3:0] OP_SHL  = 4'd8;
   localparam logic [3:0] OP_SHR  = 4'd9;
   localparam logic [3:0] OP_MUL  = 4'd10;
   localparam logic [3:0] OP_SWAP = 4'd11;

   typedef enum logic [0:0] {S_IDLE, S_MUL_RUN} state_e;

   state_e               state, state_nxt;
   logic [CW-1:0]        cnt, cnt_nxt;
   logic [WIDTH-1:0]     mcand, mcand_nxt;
   logic [2*WIDTH-1:0]   prod, prod_nxt, prod_step;
   logic [WIDTH:0]       mul_sum;

   logic [WIDTH-1:0]     out_q, out_hi_q;
   logic                 zero_q, carry_q, neg_q, ovf_q, valid_q;

   logic [WIDTH-1:0]     arith_x, arith_y;
   logic                 arith_sub, arith_ovf;
   logic [WIDTH:0]       arith;
   logic [WIDTH:0]       shl_w, shr_w;
   logic [WIDTH-1:0]     alu_lo;
   logic                 alu_carry, alu_ovf;
   logic                 is_mul;

   logic                 upd;
   logic [WIDTH-1:0]     res_lo, res_hi;
   logic                 res_carry, res_ovf;

   assign is_mul = (bus.op == OP_MUL) && (MUL_EN != 0);

   // Single-cycle datapath; shift carry falls out of the extra guard bit
   always_comb begin : alu_c
      arith_x   = bus.a;
      arith_y   = bus.b;
      arith_sub = 1'b0;
      case (bus.op)
         OP_SUB:  arith_sub = 1'b1;
         OP_INC:  begin arith_x = bus.b; arith_y = WIDTH'(1); end
         OP_DEC:  begin arith_x = bus.b; arith_y = WIDTH'(1); arith_sub = 1'b1; end
         default: ;
      endcase
      arith = arith_sub ? ({1'b0, arith_x} - {1'b0, arith_y})
                        : ({1'b0, arith_x} + {1'b0, arith_y});
      arith_ovf = arith_sub ? ((arith_x[MSB] != arith_y[MSB]) && (arith[MSB] != arith_x[MSB]))
                            : ((arith_x[MSB] == arith_y[MSB]) && (arith[MSB] != arith_x[MSB]));
      shl_w = {1'b0, bus.a} << bus.b;
      shr_w = {bus.a, 1'b0} >> bus.b;

      alu_lo    = '0;
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      case (bus.op)
         OP_PASS: alu_lo = bus.b;
         OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
            alu_lo    = arith[WIDTH-1:0];
            alu_carry = arith[WIDTH];
            alu_ovf   = arith_ovf;
         end
         OP_AND:  alu_lo = bus.a & bus.b;
         OP_OR:   alu_lo = bus.a | bus.b;
         OP_XOR:  alu_lo = bus.a ^ bus.b;
         OP_SHL:  begin alu_lo = shl_w[WIDTH-1:0]; alu_carry = shl_w[WIDTH]; end
         OP_SHR:  begin alu_lo = shr_w[WIDTH:1];   alu_carry = shr_w[0];     end
         OP_SWAP: alu_lo = {bus.a[HW-1:0], bus.a[WIDTH-1:HW]};
         default: ;
      endcase
   end

   // Next state: accept in IDLE, one multiplier bit per MUL_RUN cycle
   always_comb begin : fsm_c
      state_nxt = state;
      cnt_nxt   = cnt;
      mcand_nxt = mcand;
      prod_nxt  = prod;
      upd       = 1'b0;
      res_lo    = '0;
      res_hi    = '0;
      res_carry = 1'b0;
      res_ovf   = 1'b0;
      mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
      prod_step = {mul_sum, prod[WIDTH-1:1]};
      case (state)
         S_IDLE: begin
            if (bus.in_valid) begin
               if (is_mul) begin
                  state_nxt = S_MUL_RUN;
                  cnt_nxt   = '0;
                  mcand_nxt = bus.a;
                  prod_nxt  = {WIDTH'(0), bus.b};
               end else begin
                  upd       = 1'b1;
                  res_lo    = alu_lo;
                  res_carry = alu_carry;
                  res_ovf   = alu_ovf;
               end
            end
         end
         S_MUL_RUN: begin
            prod_nxt = prod_step;
            if (cnt == CW'(WIDTH - 1)) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
               upd       = 1'b1;
               res_lo    = prod_step[WIDTH-1:0];
               res_hi    = prod_step[2*WIDTH-1:WIDTH];
               res_carry = |prod_step[2*WIDTH-1:WIDTH];
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin : regs
      if (!rst_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         mcand    <= '0;
         prod     <= '0;
         out_q    <= '0;
         out_hi_q <= '0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
         neg_q    <= 1'b0;
         ovf_q    <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         mcand   <= mcand_nxt;
         prod    <= prod_nxt;
         valid_q <= upd;
         if (upd) begin
            out_q    <= res_lo;
            out_hi_q <= res_hi;
            zero_q   <= (res_lo == '0);
            carry_q  <= res_carry;
            neg_q    <= res_lo[MSB];
            ovf_q    <= res_ovf;
         end
      end
   end

   assign bus.in_ready   = rst_n && (state == S_IDLE);
   assign bus.out_valid  = valid_q;
   assign bus.out        = out_q;
   assign bus.out_hi     = out_hi_q;
   assign bus.flag_zero  = zero_q;
   assign bus.flag_carry = carry_q;
   assign bus.flag_neg   = neg_q;
   assign bus.flag_ovf   = ovf_q;
endmodule
